ftdi_tx_packet_arbiter: RTL

- Shares the single 32-bit TX AXI-stream input of ftdi_245fifo_top (TX_EW=2) between N_SRC independent packet sources, e.g. tx_specified_len, status and debug generators.
- Round-robin arbitration with packet lock: once a source is granted, it owns the port until its tlast or until the MAX_BEATS truncation.
- Output is registered through a skid buffer and drives tx_tvalid/tx_tdata/tx_tkeep/tx_tlast directly.

---
 rtl/ftdi_arb_pkg.sv | 21 ++
 rtl/axis_skid_buffer.sv | 50 +++++
 rtl/ftdi_tx_packet_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ftdi_arb_pkg.sv
// Shared definitions for the FTDI TX packet arbiter.
//   arb_state_e : arbiter FSM states (idle arbitration / packet pass-through)
//   DataW/KeepW : AXI-stream data and byte-enable widths of the FTDI TX port
//   clog2       : constant-evaluable ceiling log2 for sizing index fields
package ftdi_arb_pkg;

  typedef enum logic [0:0] {StIdle, StPass} arb_state_e;

  localparam int unsigned DataW = 32;
  localparam int unsigned KeepW = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer. The upstream ready comes only from a register,
// so there is no combinational path from out_ready to in_ready.
//   clk, rstn                      : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      : upstream stream
//   out_valid/out_ready/out_data   : downstream stream (registered)
module axis_skid_buffer #(
  parameter int unsigned Width = 37
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             out_valid_q;
  logic             skid_valid_q;
  logic [Width-1:0] out_data_q;
  logic [Width-1:0] skid_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else if (skid_valid_q) begin
      // Upstream is stalled; drain the skid entry into the output register.
      if (out_ready) begin
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end
    end else if (!out_valid_q || out_ready) begin
      out_valid_q <= in_valid;
      if (in_valid) out_data_q <= in_data;
    end else if (in_valid) begin
      // Output is stuck but ready was already promised: park the beat.
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/ftdi_tx_packet_arbiter.sv
// Round-robin packet arbiter sharing the FTDI 32-bit TX stream between N_SRC sources.
// A granted source owns the port until its tlast or until MAX_BEATS beats (truncation).
//   clk, rstn            : clock, asynchronous active-low reset
//   src_en               : per-source enable, only looked at during arbitration
//   s_t*                 : packed per-source AXI-stream inputs (source i at slice i)
//   m_t*                 : registered output stream to the FTDI TX port
//   grant_id, busy       : current/last granted source, high while passing a burst
//   trunc_pulse          : one cycle after a burst was cut at MAX_BEATS
//   pkt_cnt              : per-source completed-burst counters (wrapping)
module ftdi_tx_packet_arbiter
  import ftdi_arb_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned MAX_BEATS = 4096,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned GW       = (N_SRC > 1) ? clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_SRC-1:0]       src_en,
  input  logic [N_SRC-1:0]       s_tvalid,
  output logic [N_SRC-1:0]       s_tready,
  input  logic [N_SRC*32-1:0]    s_tdata,
  input  logic [N_SRC*4-1:0]     s_tkeep,
  input  logic [N_SRC-1:0]       s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [31:0]            m_tdata,
  output logic [3:0]             m_tkeep,
  output logic                   m_tlast,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   trunc_pulse,
  output logic [N_SRC*CNT_W-1:0] pkt_cnt
);

  localparam int unsigned BufW = DataW + KeepW + 1;

  arb_state_e             state_q;
  logic [GW-1:0]          grant_q;
  logic [GW-1:0]          rr_ptr_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [N_SRC*CNT_W-1:0] pkt_cnt_q;
  logic                   trunc_q;

  logic [N_SRC-1:0] req;
  logic             req_any;
  logic [GW-1:0]    req_pick;
  logic [GW-1:0]    idx;

  logic             g_valid;
  logic             g_last;
  logic [DataW-1:0] g_data;
  logic [KeepW-1:0] g_keep;
  logic             max_hit;
  logic             beat_acc;
  logic             buf_in_valid;
  logic             buf_in_ready;
  logic [BufW-1:0]  buf_in_data;
  logic [BufW-1:0]  buf_out_data;

  assign req = s_tvalid & src_en;

  // First requester searching upward from rr_ptr+1, wrapping.
  always_comb begin
    req_any  = 1'b0;
    req_pick = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      idx = GW'((32'(rr_ptr_q) + k) % N_SRC);
      if (!req_any && req[idx]) begin
        req_any  = 1'b1;
        req_pick = idx;
      end
    end
  end

  assign g_valid = s_tvalid[grant_q];
  assign g_last  = s_tlast[grant_q];
  assign g_data  = s_tdata[grant_q*DataW +: DataW];
  assign g_keep  = s_tkeep[grant_q*KeepW +: KeepW];

  // Current beat is number beat_cnt_q+1 of this burst.
  assign max_hit = (MAX_BEATS != 0) && ((32'(beat_cnt_q) + 32'd1) == MAX_BEATS);

  assign busy         = (state_q == StPass);
  assign buf_in_valid = busy && g_valid;
  assign beat_acc     = buf_in_valid && buf_in_ready;
  assign buf_in_data  = {g_last | max_hit, g_keep, g_data};

  always_comb begin
    s_tready = '0;
    if (busy) s_tready[grant_q] = buf_in_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= GW'(N_SRC - 1);
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      trunc_q    <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_any) begin
            grant_q  <= req_pick;
            rr_ptr_q <= req_pick;
            state_q  <= StPass;
          end
        end
        StPass: begin
          if (beat_acc) begin
            if (g_last || max_hit) begin
              beat_cnt_q <= '0;
              pkt_cnt_q[grant_q*CNT_W +: CNT_W] <=
                  pkt_cnt_q[grant_q*CNT_W +: CNT_W] + CNT_W'(1);
              trunc_q    <= max_hit && !g_last;
              state_q    <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_skid_buffer #(
    .Width (BufW)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .in_data   (buf_in_data),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .out_data  (buf_out_data)
  );

  assign m_tdata     = buf_out_data[DataW-1:0];
  assign m_tkeep     = buf_out_data[DataW +: KeepW];
  assign m_tlast     = buf_out_data[BufW-1];
  assign grant_id    = grant_q;
  assign trunc_pulse = trunc_q;
  assign pkt_cnt     = pkt_cnt_q;

endmodule
